// File: rtl/time_entry_pkg.sv
// Shared timer package: key-controller FSM states, debounce default and a
// small saturating-counter helper used by the keypad entry controller.
// No ports (package).
package time_entry_pkg;

    // Consecutive stable samples required to accept a key press or release.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

    // Largest seconds-units value that may still shift into the tens place.
    localparam logic [3:0] MAX_SHIFT_DIGIT = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS    = 3'd1,
        ST_ACCEPT   = 3'd2,
        ST_WAIT_REL = 3'd3,
        ST_REL      = 3'd4
    } key_state_t;

    // Two-bit counter increment that sticks at 3.
    function automatic logic [1:0] sat_inc2(input logic [1:0] value);
        if (value == 2'd3) begin
            return 2'd3;
        end else begin
            return value + 2'd1;
        end
    endfunction

endpackage

// File: rtl/time_entry_if.sv
// Keypad entry bus: raw keys and control levels in, BCD time digits, load
// strobe, digit count and error pulse out.
//   master : drives keypad/enable/clear/start, observes the outputs
//   slave  : the time_entry controller
interface time_entry_if;

    logic [9:0] keypad;
    logic       enable;
    logic       clear;
    logic       start;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] mins;
    logic       loadn;
    logic [1:0] digit_count;
    logic       err;

    modport master (
        output keypad, enable, clear, start,
        input  sec_ones, sec_tens, mins, loadn, digit_count, err
    );

    modport slave (
        input  keypad, enable, clear, start,
        output sec_ones, sec_tens, mins, loadn, digit_count, err
    );

endinterface

// File: rtl/time_entry_key_encoder.sv
// Combinational one-hot key decoder.
//   keys  : registered key lines, bit n = digit n pressed
//   digit : BCD value of the pressed key (meaningful only when valid)
//   valid : exactly one key line is high
//   multi : more than one key line is high
module time_entry_key_encoder (
    input  logic [9:0] keys,
    output logic [3:0] digit,
    output logic       valid,
    output logic       multi
);

    logic [3:0] ones;

    // Count the active lines and record the position of a set line
    always_comb begin
        ones  = 4'd0;
        digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keys[i]) begin
                ones  = ones + 4'd1;
                digit = 4'(i);
            end else begin
                ones  = ones;
            end
        end
        valid = (ones == 4'd1);
        multi = (ones > 4'd1);
    end

endmodule

// File: rtl/time_entry.sv
// Microwave keypad time-entry controller. Debounces a 10-key keypad, shifts
// accepted digits into a three-digit M:SS register, and issues a one-cycle
// active-low load strobe to the down-counter chain on a start request.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : time_entry_if slave (keypad, enable, clear, start in;
//               sec_ones, sec_tens, mins, loadn, digit_count, err out)
module time_entry
    import time_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic         clk,
    input  logic         rstn,
    time_entry_if.slave  bus
);

    // Count value on the cycle that observes the final stable sample.
    localparam logic [7:0] LAST_COUNT = 8'(DEBOUNCE_CYCLES - 1);

    logic [9:0]  key_q_r;
    logic        start_q_r;
    key_state_t  state_r;
    key_state_t  state_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_s;
    logic [3:0]  code_r;
    logic [3:0]  code_s;
    logic [3:0]  sec_ones_r;
    logic [3:0]  sec_tens_r;
    logic [3:0]  mins_r;
    logic [1:0]  digit_count_r;
    logic        loadn_r;
    logic        err_r;

    logic [3:0]  enc_digit_s;
    logic        enc_valid_s;
    logic        enc_multi_s;
    logic        key_any_s;
    logic        accept_s;
    logic        reject_s;
    logic        start_fire_s;
    logic        digits_nonzero_s;

    time_entry_key_encoder key_encoder (
        .keys  (key_q_r),
        .digit (enc_digit_s),
        .valid (enc_valid_s),
        .multi (enc_multi_s)
    );

    assign key_any_s = |key_q_r;

    // Input sampling: only the registered keypad feeds the FSM; start history for edge detect
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_q_r   <= 10'd0;
            start_q_r <= 1'b0;
        end else begin
            key_q_r   <= bus.keypad;
            start_q_r <= bus.start;
        end
    end

    // FSM state register with debounce counter and captured key code
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
            code_r  <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            code_r  <= code_s;
        end
    end

    // FSM next-state: debounce press and release; enable low and clear override
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        code_s  = code_r;
        if (!bus.enable) begin
            state_s = ST_IDLE;
            cnt_s   = 8'd0;
        end else if (bus.clear) begin
            // A key still down after clear must be released before the next press counts.
            state_s = key_any_s ? ST_WAIT_REL : ST_IDLE;
            cnt_s   = 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enc_multi_s) begin
                        cnt_s = 8'd0;
                    end else if (enc_valid_s) begin
                        state_s = ST_PRESS;
                        cnt_s   = 8'd1;
                        code_s  = enc_digit_s;
                    end else begin
                        cnt_s = 8'd0;
                    end
                end
                ST_PRESS: begin
                    if (enc_valid_s && !enc_multi_s && (enc_digit_s == code_r)) begin
                        if (cnt_r == LAST_COUNT) begin
                            state_s = ST_ACCEPT;
                            cnt_s   = 8'd0;
                        end else begin
                            cnt_s = cnt_r + 8'd1;
                        end
                    end else begin
                        state_s = ST_IDLE;
                        cnt_s   = 8'd0;
                    end
                end
                ST_ACCEPT: begin
                    state_s = ST_WAIT_REL;
                    cnt_s   = 8'd0;
                end
                ST_WAIT_REL: begin
                    if (!key_any_s) begin
                        state_s = ST_REL;
                        cnt_s   = 8'd1;
                    end else begin
                        cnt_s = 8'd0;
                    end
                end
                ST_REL: begin
                    if (key_any_s) begin
                        state_s = ST_WAIT_REL;
                        cnt_s   = 8'd0;
                    end else if (cnt_r == LAST_COUNT) begin
                        state_s = ST_IDLE;
                        cnt_s   = 8'd0;
                    end else begin
                        cnt_s = cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = 8'd0;
                end
            endcase
        end
    end

    // FSM output decode: accept/reject of the debounced key and start qualification
    always_comb begin
        // The digit registers update on the edge that enters ACCEPT, so the new
        // value (or the err pulse) is presented during the single ACCEPT cycle.
        accept_s         = (state_r == ST_PRESS) && (state_s == ST_ACCEPT);
        reject_s         = accept_s && (sec_ones_r > MAX_SHIFT_DIGIT);
        digits_nonzero_s = (sec_ones_r != 4'd0) || (sec_tens_r != 4'd0) || (mins_r != 4'd0);
        start_fire_s     = bus.enable && bus.start && !start_q_r && !bus.clear;
    end

    // Digit shift register, digit count, load strobe and error pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sec_ones_r    <= 4'd0;
            sec_tens_r    <= 4'd0;
            mins_r        <= 4'd0;
            digit_count_r <= 2'd0;
            loadn_r       <= 1'b1;
            err_r         <= 1'b0;
        end else begin
            loadn_r <= 1'b1;
            err_r   <= 1'b0;
            if (bus.clear) begin
                sec_ones_r    <= 4'd0;
                sec_tens_r    <= 4'd0;
                mins_r        <= 4'd0;
                digit_count_r <= 2'd0;
            end else begin
                if (accept_s) begin
                    if (reject_s) begin
                        err_r <= 1'b1;
                    end else begin
                        mins_r        <= sec_tens_r;
                        sec_tens_r    <= sec_ones_r;
                        sec_ones_r    <= code_r;
                        digit_count_r <= sat_inc2(digit_count_r);
                    end
                end else begin
                    digit_count_r <= digit_count_r;
                end
                if (start_fire_s) begin
                    if (digits_nonzero_s) begin
                        loadn_r <= 1'b0;
                    end else begin
                        err_r <= 1'b1;
                    end
                end else begin
                    loadn_r <= 1'b1;
                end
            end
        end
    end

    assign bus.sec_ones    = sec_ones_r;
    assign bus.sec_tens    = sec_tens_r;
    assign bus.mins        = mins_r;
    assign bus.digit_count = digit_count_r;
    assign bus.loadn       = loadn_r;
    assign bus.err         = err_r;

endmodule

// File: tb/tb_time_entry.sv
// Testbench for time_entry (DEBOUNCE_CYCLES = 4). Directed key/start/clear
// sequences push the expected output snapshot and the edge at which it must
// appear into a queue; a monitor compares every observed output change.
module tb_time_entry;

    typedef struct {
        logic [15:0] value;
        int          edge_at;
    } ev_t;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    always #5 clk = ~clk;

    time_entry_if bus ();

    time_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    ev_t         sb[$];
    int          checks    = 0;
    int          failures  = 0;
    int          edge_cnt  = 0;
    logic        mon_on    = 1'b0;
    logic        first     = 1'b1;
    logic        fin_req   = 1'b0;
    logic        fin_done  = 1'b0;
    logic [15:0] prev_snap = 16'd0;

    function automatic logic [15:0] pack(input logic [3:0] m, input logic [3:0] s10,
                                         input logic [3:0] s1, input logic [1:0] dc,
                                         input logic ld, input logic er);
        return {m, s10, s1, dc, ld, er};
    endfunction

    task automatic ex(input logic [3:0] m, input logic [3:0] s10, input logic [3:0] s1,
                      input logic [1:0] dc, input logic ld, input logic er, input int at);
        ev_t e;
        e.value   = pack(m, s10, s1, dc, ld, er);
        e.edge_at = at;
        sb.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key_hold(input int k, input int hold, input int rel);
        bus.keypad = 10'd1 << k;
        cyc(hold);
        bus.keypad = 10'd0;
        cyc(rel);
    endtask

    // Edge counter: value N at a negedge means N rising edges have occurred
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: compare each output change with the head of the scoreboard
    always @(negedge clk) begin
        logic [15:0] cur;
        ev_t         ev;
        cur = {bus.mins, bus.sec_tens, bus.sec_ones, bus.digit_count, bus.loadn, bus.err};
        if (mon_on) begin
            if (first) begin
                checks++;
                if (cur != pack(4'd0, 4'd0, 4'd0, 2'd0, 1'b1, 1'b0)) begin
                    failures++;
                    $display("FAIL reset_state: got %h required %h", cur,
                             pack(4'd0, 4'd0, 4'd0, 2'd0, 1'b1, 1'b0));
                end
                first = 1'b0;
            end else if (cur != prev_snap) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change: got %h at edge %0d, required no change from %h",
                             cur, edge_cnt, prev_snap);
                end else begin
                    ev = sb.pop_front();
                    if ((cur != ev.value) || (edge_cnt != ev.edge_at)) begin
                        failures++;
                        $display("FAIL output_change: got %h at edge %0d, required %h at edge %0d",
                                 cur, edge_cnt, ev.value, ev.edge_at);
                    end
                end
            end
            if (fin_req && !fin_done) begin
                while (sb.size() > 0) begin
                    ev = sb.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL missing_change: got none, required %h at edge %0d",
                             ev.value, ev.edge_at);
                end
                fin_done = 1'b1;
            end
        end
        prev_snap = cur;
    end

    // Stimulus
    initial begin
        int base;
        bus.keypad = 10'd0;
        bus.enable = 1'b1;
        bus.clear  = 1'b0;
        bus.start  = 1'b0;
        #1 rstn = 1'b0;
        cyc(3);
        mon_on = 1'b1;
        cyc(2);
        #1 rstn = 1'b1;
        cyc(3);

        // Key 5 held 6 cycles: digit appears 5 edges after first presentation
        base = edge_cnt; ex(4'd0, 4'd0, 4'd5, 2'd1, 1'b1, 1'b0, base + 5);
        key_hold(5, 6, 6);

        // Key 3 bounce of only 2 cycles: no change
        key_hold(3, 2, 6);

        // Clear
        base = edge_cnt; ex(4'd0, 4'd0, 4'd0, 2'd0, 1'b1, 1'b0, base + 1);
        bus.clear = 1'b1; cyc(1); bus.clear = 1'b0; cyc(2);

        // Enter 1,3,0,0 -> 3:00, count saturates at 3
        base = edge_cnt; ex(4'd0, 4'd0, 4'd1, 2'd1, 1'b1, 1'b0, base + 5); key_hold(1, 6, 6);
        base = edge_cnt; ex(4'd0, 4'd1, 4'd3, 2'd2, 1'b1, 1'b0, base + 5); key_hold(3, 6, 6);
        base = edge_cnt; ex(4'd1, 4'd3, 4'd0, 2'd3, 1'b1, 1'b0, base + 5); key_hold(0, 6, 6);
        base = edge_cnt; ex(4'd3, 4'd0, 4'd0, 2'd3, 1'b1, 1'b0, base + 5); key_hold(0, 6, 6);

        // Held start: exactly one loadn low cycle, digits hold
        base = edge_cnt;
        ex(4'd3, 4'd0, 4'd0, 2'd3, 1'b0, 1'b0, base + 1);
        ex(4'd3, 4'd0, 4'd0, 2'd3, 1'b1, 1'b0, base + 2);
        bus.start = 1'b1; cyc(4); bus.start = 1'b0; cyc(2);

        base = edge_cnt; ex(4'd0, 4'd0, 4'd0, 2'd0, 1'b1, 1'b0, base + 1);
        bus.clear = 1'b1; cyc(1); bus.clear = 1'b0; cyc(2);

        // 7 then 2: second key rejected because 7 cannot become a tens digit
        base = edge_cnt; ex(4'd0, 4'd0, 4'd7, 2'd1, 1'b1, 1'b0, base + 5); key_hold(7, 6, 6);
        base = edge_cnt;
        ex(4'd0, 4'd0, 4'd7, 2'd1, 1'b1, 1'b1, base + 5);
        ex(4'd0, 4'd0, 4'd7, 2'd1, 1'b1, 1'b0, base + 6);
        key_hold(2, 6, 6);

        base = edge_cnt; ex(4'd0, 4'd0, 4'd0, 2'd0, 1'b1, 1'b0, base + 1);
        bus.clear = 1'b1; cyc(1); bus.clear = 1'b0; cyc(2);

        // 0:45 then start and clear together: clear wins, no load, no err
        base = edge_cnt; ex(4'd0, 4'd0, 4'd4, 2'd1, 1'b1, 1'b0, base + 5); key_hold(4, 6, 6);
        base = edge_cnt; ex(4'd0, 4'd4, 4'd5, 2'd2, 1'b1, 1'b0, base + 5); key_hold(5, 6, 6);
        base = edge_cnt; ex(4'd0, 4'd0, 4'd0, 2'd0, 1'b1, 1'b0, base + 1);
        bus.start = 1'b1; bus.clear = 1'b1; cyc(1);
        bus.start = 1'b0; bus.clear = 1'b0; cyc(2);

        // Start with all digits zero: err pulse, loadn stays high
        base = edge_cnt;
        ex(4'd0, 4'd0, 4'd0, 2'd0, 1'b1, 1'b1, base + 1);
        ex(4'd0, 4'd0, 4'd0, 2'd0, 1'b1, 1'b0, base + 2);
        bus.start = 1'b1; cyc(3); bus.start = 1'b0; cyc(2);

        // Enable low: key and start ignored, clear still effective
        base = edge_cnt; ex(4'd0, 4'd0, 4'd8, 2'd1, 1'b1, 1'b0, base + 5); key_hold(8, 6, 6);
        bus.enable = 1'b0; cyc(1);
        key_hold(6, 6, 6);
        bus.start = 1'b1; cyc(3); bus.start = 1'b0; cyc(2);
        base = edge_cnt; ex(4'd0, 4'd0, 4'd0, 2'd0, 1'b1, 1'b0, base + 1);
        bus.clear = 1'b1; cyc(1); bus.clear = 1'b0; cyc(2);
        bus.enable = 1'b1; cyc(2);

        // Reset mid-debounce with key 9 held: fresh full debounce afterwards
        base = edge_cnt; ex(4'd0, 4'd0, 4'd2, 2'd1, 1'b1, 1'b0, base + 5); key_hold(2, 6, 6);
        base = edge_cnt; ex(4'd0, 4'd0, 4'd0, 2'd0, 1'b1, 1'b0, base + 3);
        bus.keypad = 10'd1 << 9;
        cyc(2);
        #1 rstn = 1'b0;
        cyc(3);
        #1 rstn = 1'b1;
        base = base + 5;
        ex(4'd0, 4'd0, 4'd9, 2'd1, 1'b1, 1'b0, base + 5);
        cyc(8);
        bus.keypad = 10'd0;
        cyc(8);

        fin_req = 1'b1;
        cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/time_entry.md
TIME_ENTRY -- requirements
Module: time_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable samples needed to accept a key press or release (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port keypad, input, 10, raw key lines; bit n high means key digit n is pressed.
REQ-005 SHALL have port enable, input, 1, entry allowed; high when the oven is idle.
REQ-006 SHALL have port clear, input, 1, level; empties the entered time.
REQ-007 SHALL have port start, input, 1, level; requests a load of the entered time into the down-counter chain.
REQ-008 SHALL have port sec_ones, output, 4, BCD seconds units (data for the units counter10).
REQ-009 SHALL have port sec_tens, output, 4, BCD seconds tens (0..5).
REQ-010 SHALL have port mins, output, 4, BCD minutes (0..9).
REQ-011 SHALL have port loadn, output, 1, active-low load strobe to the counter chain.
REQ-012 SHALL have port digit_count, output, 2, number of digits entered (0..3, saturating).
REQ-013 SHALL have port err, output, 1, one-cycle pulse on a rejected key or rejected start.

Function
REQ-014 SHALL register keypad through one flop (key_q) before any decision; only key_q drives the FSM.
REQ-015 SHALL treat a key_q value as a valid code only when exactly one bit is set; zero means released; multiple bits set means invalid and resets the debounce count.
REQ-016 SHALL run the FSM IDLE -> PRESS (valid code seen) -> ACCEPT (same code held DEBOUNCE_CYCLES consecutive samples) -> WAIT_REL -> REL (key_q zero) -> IDLE (zero held DEBOUNCE_CYCLES samples).
REQ-017 SHALL return PRESS to IDLE if the code changes or becomes zero or invalid before the count completes; SHALL return REL to WAIT_REL if any bit reappears.
REQ-018 SHALL act on the key in ACCEPT for exactly one cycle; the digit update is visible DEBOUNCE_CYCLES+1 rising edges after keypad first presents a stable code.
REQ-019 SHALL shift on accept: mins <= sec_tens, sec_tens <= sec_ones, sec_ones <= new digit; the old mins is discarded.
REQ-020 SHALL reject an accept when the old sec_ones is greater than 5: digits unchanged, err pulses for one cycle, FSM still goes to WAIT_REL.
REQ-021 SHALL increment digit_count on each non-rejected accept, saturating at 3.
REQ-022 SHALL, on start high while enable is high with any digit nonzero, drive loadn low for exactly one cycle on the next edge; digits hold their values afterwards.
REQ-023 SHALL, on start with all digits zero, keep loadn high and pulse err.
REQ-024 SHALL accept start on its rising edge only; a held start gives one loadn pulse.
REQ-025 SHALL, on clear high, zero all digits and digit_count on the next edge and force the FSM to WAIT_REL if any key is held, otherwise IDLE.
REQ-026 SHALL give clear priority over start and over a same-cycle accept; no loadn, no err.
REQ-027 SHALL, with enable low, ignore keypad and start, hold the digits, and force the FSM to IDLE; clear still works.

Reset
REQ-028 SHALL, on rstn low, asynchronously set sec_ones, sec_tens, mins to 0, digit_count to 0, loadn to 1, err to 0, key_q to 0, the debounce count to 0, and the FSM to IDLE.
REQ-029 SHALL treat a key still held when rstn deasserts as a new press that must be debounced in full.

Structure
REQ-030 SHALL place the FSM state enumeration and the DEBOUNCE_CYCLES default in the shared timer package, for use by the counter chain and the controller.
REQ-031 SHALL use one sub-module, key_encoder: combinational one-hot-to-BCD with a valid flag, plus a multiple-keys-pressed flag.

Verification
REQ-032 Hold key 5 for 6 cycles, DEBOUNCE_CYCLES=4 -> sec_ones=5 after edge 5, digit_count=1, no err.
REQ-033 Hold key 3 for 2 cycles, then release -> digits unchanged, digit_count=0.
REQ-034 Enter 1,3,0,0 (each held 6 cycles, released 6 cycles) -> mins=3, sec_tens=0, sec_ones=0, digit_count=3; then start -> a single one-cycle loadn low.
REQ-035 Enter 7, then 2 -> second key rejected: err pulses once, sec_ones=7, sec_tens=0.
REQ-036 With start and clear high in the same cycle, digits at 0,4,5 -> all digits 0, loadn stays high, no err.
REQ-037 Assert rstn low mid-debounce while key 9 is held, then release rstn -> all outputs at reset values; 9 is accepted only after a fresh DEBOUNCE_CYCLES+1 edges.
